alu_sequencer: RTL and testbench

Command-driven controller that sits on the operand side of the combinational 4-bit ALU. It accepts instruction words {INST, A, B} over a valid/ready handshake, buffers them in a small FIFO, and drives the ALU's A, B and INST inputs. After a fixed settle time it captures the ALU's 8-bit result and presents it, tagged with its opcode, on a valid/ready result port. It replaces hand-written stimulus sequences wherever the ALU is driven from other logic.

---
 rtl/alu_sequencer.sv | 141 ++++++++++++++
 tb/tb_alu_sequencer.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// Command sequencer for the 4-bit ALU: queues {INST, A, B} words, drives the
// ALU operands, waits a fixed settle time and hands the result back in order.
module alu_sequencer #(
    parameter int DEPTH    = 4,
    parameter int WAIT_CYC = 1
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        iCMD_VALID,
    input  logic [11:0] iCMD,
    output logic        oCMD_READY,
    output logic [3:0]  oA,
    output logic [3:0]  oB,
    output logic [3:0]  oINST,
    input  logic [7:0]  iRESULT,
    output logic        oRES_VALID,
    output logic [7:0]  oRES,
    output logic [3:0]  oRES_INST,
    input  logic        iRES_READY,
    output logic        oBUSY,
    output logic [7:0]  oCNT
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int WW = $clog2(WAIT_CYC + 1);

    typedef enum logic [1:0] {
        stIdle,
        stWait,
        stHold
    } seqState;

    seqState       state;
    logic [WW-1:0] waitCnt;

    logic [11:0]   fifoMem [DEPTH];
    logic [PW-1:0] wrPtr;
    logic [PW-1:0] rdPtr;
    logic [CW-1:0] fillCount;
    logic          fifoFull;
    logic          fifoEmpty;
    logic          push;
    logic          pop;
    logic          resAccept;
    logic [11:0]   headCmd;

    assign fifoFull   = (fillCount == CW'(DEPTH));
    assign fifoEmpty  = (fillCount == '0);
    assign oCMD_READY = !iRST && !fifoFull;
    assign push       = iCMD_VALID && oCMD_READY;
    assign resAccept  = oRES_VALID && iRES_READY;
    assign headCmd    = fifoMem[rdPtr];

    // The head leaves the queue when the FSM is free to issue it: from IDLE, or
    // straight out of HOLD on the same edge the current result is taken.
    assign pop = !fifoEmpty && ((state == stIdle) || ((state == stHold) && resAccept));

    assign oBUSY = !fifoEmpty || (state != stIdle);

    always_ff @(posedge iCLK) begin
        if (push) begin
            fifoMem[wrPtr] <= iCMD;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two; the separate
    // occupancy count keeps full/empty unambiguous.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            wrPtr     <= '0;
            rdPtr     <= '0;
            fillCount <= '0;
        end else begin
            if (push) begin
                wrPtr <= wrPtr + PW'(1);
            end
            if (pop) begin
                rdPtr <= rdPtr + PW'(1);
            end
            case ({push, pop})
                2'b10:   fillCount <= fillCount + CW'(1);
                2'b01:   fillCount <= fillCount - CW'(1);
                default: fillCount <= fillCount;
            endcase
        end
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state      <= stIdle;
            waitCnt    <= '0;
            oA         <= '0;
            oB         <= '0;
            oINST      <= '0;
            oRES       <= '0;
            oRES_INST  <= '0;
            oRES_VALID <= 1'b0;
            oCNT       <= '0;
        end else begin
            case (state)
                stIdle: begin
                    if (pop) begin
                        {oINST, oA, oB} <= headCmd;
                        waitCnt         <= WW'(WAIT_CYC);
                        state           <= stWait;
                    end
                end
                stWait: begin
                    // The final count is the edge where the ALU output is trusted.
                    if (waitCnt == WW'(1)) begin
                        waitCnt    <= '0;
                        oRES       <= iRESULT;
                        oRES_INST  <= oINST;
                        oRES_VALID <= 1'b1;
                        state      <= stHold;
                    end else begin
                        waitCnt <= waitCnt - WW'(1);
                    end
                end
                stHold: begin
                    if (resAccept) begin
                        oRES_VALID <= 1'b0;
                        oCNT       <= oCNT + 8'd1;
                        if (pop) begin
                            {oINST, oA, oB} <= headCmd;
                            waitCnt         <= WW'(WAIT_CYC);
                            state           <= stWait;
                        end else begin
                            state <= stIdle;
                        end
                    end
                end
                default: begin
                    state <= stIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Randomised and directed checks of alu_sequencer against an in-order result
// scoreboard; two instances cover the short and the long settle time.
module tb_alu_sequencer;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmdValid [2];
    logic [11:0] cmd      [2];
    logic        cmdReady [2];
    logic [3:0]  aOut     [2];
    logic [3:0]  bOut     [2];
    logic [3:0]  instOut  [2];
    logic        resValid [2];
    logic [7:0]  res      [2];
    logic [3:0]  resInst  [2];
    logic        resReady [2];
    logic        busy     [2];
    logic [7:0]  cnt      [2];

    int waitCyc [2] = '{1, 3};

    int assertCount = 0;
    int failCount   = 0;

    logic [11:0] expQ [$];
    int  expCnt [2];
    int  cycle;
    int  lastFire;
    int  fireCount;
    bit  gapCheck;
    bit  saw255;

    always #5 clk = ~clk;

    alu_sequencer #(.DEPTH(DEPTH), .WAIT_CYC(1)) dutFast (
        .iCLK       (clk),
        .iRST       (rst),
        .iCMD_VALID (cmdValid[0]),
        .iCMD       (cmd[0]),
        .oCMD_READY (cmdReady[0]),
        .oA         (aOut[0]),
        .oB         (bOut[0]),
        .oINST      (instOut[0]),
        .iRESULT    ({aOut[0], bOut[0]}),
        .oRES_VALID (resValid[0]),
        .oRES       (res[0]),
        .oRES_INST  (resInst[0]),
        .iRES_READY (resReady[0]),
        .oBUSY      (busy[0]),
        .oCNT       (cnt[0])
    );

    alu_sequencer #(.DEPTH(DEPTH), .WAIT_CYC(3)) dutSlow (
        .iCLK       (clk),
        .iRST       (rst),
        .iCMD_VALID (cmdValid[1]),
        .iCMD       (cmd[1]),
        .oCMD_READY (cmdReady[1]),
        .oA         (aOut[1]),
        .oB         (bOut[1]),
        .oINST      (instOut[1]),
        .iRESULT    ({aOut[1], bOut[1]}),
        .oRES_VALID (resValid[1]),
        .oRES       (res[1]),
        .oRES_INST  (resInst[1]),
        .iRES_READY (resReady[1]),
        .oBUSY      (busy[1]),
        .oCNT       (cnt[1])
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // One clock of stimulus on instance d; the stub ALU returns {A, B}, so the
    // expected {RES_INST, RES} of every command is the command word itself.
    task automatic applyStimulus(input int d, input logic v, input logic [11:0] c,
                                 input logic rr, output logic fired);
        logic cmdFire;
        logic resFire;
        logic [11:0] e;
        cmdValid[d] = v;
        cmd[d]      = c;
        resReady[d] = rr;
        @(negedge clk);
        cmdFire = cmdValid[d] && cmdReady[d];
        resFire = resValid[d] && resReady[d];
        if (resFire) begin
            if (expQ.size() == 0) begin
                checkOutput("spuriousResult", 32'(resValid[d]), 32'(0));
            end else begin
                e = expQ.pop_front();
                checkOutput("resData", 32'({resInst[d], res[d]}), 32'(e));
            end
            if (gapCheck && lastFire >= 0) begin
                checkOutput("resGap", 32'(cycle - lastFire), 32'(waitCyc[d] + 1));
            end
            lastFire  = cycle;
            fireCount++;
            expCnt[d] = (expCnt[d] + 1) % 256;
        end
        if (cmdFire) begin
            expQ.push_back(cmd[d]);
        end
        @(posedge clk);
        #1;
        cycle++;
        if (resFire) begin
            checkOutput("resCount", 32'(cnt[d]), 32'(expCnt[d]));
            if (expCnt[d] == 255 && cnt[d] == 8'd255) begin
                saw255 = 1'b1;
            end
        end
        fired = cmdFire;
    endtask

    task automatic doReset();
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            cmdValid[d] = 1'b0;
            cmd[d]      = '0;
            resReady[d] = 1'b1;
        end
        repeat (3) @(posedge clk);
        #1;
        checkOutput("readyInReset", 32'(cmdReady[0]), 32'(0));
        @(negedge clk);
        rst = 1'b0;
        expQ.delete();
        expCnt[0] = 0;
        expCnt[1] = 0;
        @(posedge clk);
        #1;
    endtask

    task automatic runSweep(input int d);
        logic f;
        int k = 0;
        int budget = 300;
        gapCheck  = 1'b1;
        lastFire  = -1;
        fireCount = 0;
        while ((k < 16 || expQ.size() != 0) && budget > 0) begin
            applyStimulus(d, k < 16, {k[3:0], 4'ha, 4'h6}, 1'b1, f);
            if (f) k++;
            budget--;
        end
        checkOutput("sweepResults", 32'(fireCount), 32'(16));
        checkOutput("sweepDrained", 32'(expQ.size()), 32'(0));
        checkOutput("sweepIdle", 32'(busy[d]), 32'(0));
        gapCheck = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic f;
        int k;
        int budget;
        logic [11:0] rc;
        logic v;
        logic rr;

        cycle    = 0;
        gapCheck = 1'b0;
        lastFire = -1;
        saw255   = 1'b0;

        // Reset values on both instances.
        doReset();
        for (int d = 0; d < 2; d++) begin
            checkOutput("rstReady", 32'(cmdReady[d]), 32'(1));
            checkOutput("rstResValid", 32'(resValid[d]), 32'(0));
            checkOutput("rstCnt", 32'(cnt[d]), 32'(0));
            checkOutput("rstOperands", 32'({instOut[d], aOut[d], bOut[d]}), 32'(0));
            checkOutput("rstBusy", 32'(busy[d]), 32'(0));
        end

        // Single command latency.
        applyStimulus(0, 1'b1, 12'h2a6, 1'b1, f);
        checkOutput("singleAccepted", 32'(f), 32'(1));
        applyStimulus(0, 1'b0, 12'h000, 1'b1, f);
        checkOutput("singleOperands", 32'({instOut[0], aOut[0], bOut[0]}), 32'h2a6);
        checkOutput("singleEarlyValid", 32'(resValid[0]), 32'(0));
        applyStimulus(0, 1'b0, 12'h000, 1'b1, f);
        checkOutput("singleResValid", 32'(resValid[0]), 32'(1));
        checkOutput("singleRes", 32'({resInst[0], res[0]}), 32'h2a6);
        applyStimulus(0, 1'b0, 12'h000, 1'b1, f);
        checkOutput("singleCnt", 32'(cnt[0]), 32'(1));
        checkOutput("singleValidCleared", 32'(resValid[0]), 32'(0));

        // Reset asserted while a command is in WAIT.
        applyStimulus(0, 1'b1, 12'h5c3, 1'b1, f);
        applyStimulus(0, 1'b0, 12'h000, 1'b1, f);
        rst = 1'b1;
        #1;
        checkOutput("midRstValid", 32'(resValid[0]), 32'(0));
        checkOutput("midRstBusy", 32'(busy[0]), 32'(0));
        expQ.delete();
        expCnt[0] = 0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        fireCount = 0;
        repeat (6) applyStimulus(0, 1'b0, 12'h000, 1'b1, f);
        checkOutput("midRstNoResult", 32'(fireCount), 32'(0));
        checkOutput("midRstCnt", 32'(cnt[0]), 32'(0));

        // Fill the FIFO with the consumer stalled.
        k = 0;
        for (int i = 0; i < 9; i++) begin
            rc = {k[3:0], 8'($urandom)};
            applyStimulus(0, k < 6, rc, 1'b0, f);
            if (f) begin
                checkOutput("acceptEdge", 32'(i), 32'(k));
                k++;
            end
            if (i == 4) checkOutput("fullReady", 32'(cmdReady[0]), 32'(0));
        end
        checkOutput("fullAccepted", 32'(k), 32'(5));
        checkOutput("fullBusy", 32'(busy[0]), 32'(1));

        // Drain in order with the consumer always ready.
        gapCheck  = 1'b1;
        lastFire  = -1;
        fireCount = 0;
        budget    = 40;
        while (expQ.size() != 0 && budget > 0) begin
            applyStimulus(0, 1'b0, 12'h000, 1'b1, f);
            budget--;
        end
        gapCheck = 1'b0;
        checkOutput("drainDone", 32'(expQ.size()), 32'(0));
        checkOutput("drainResults", 32'(fireCount), 32'(5));
        checkOutput("drainCnt", 32'(cnt[0]), 32'(5));
        checkOutput("drainIdle", 32'(busy[0]), 32'(0));

        // Opcode sweep at both settle times.
        runSweep(0);
        runSweep(1);

        // Counter wrap with random stalls on both sides.
        doReset();
        saw255    = 1'b0;
        fireCount = 0;
        k         = 0;
        budget    = 8000;
        while ((k < 256 || expQ.size() != 0) && budget > 0) begin
            rc = 12'($urandom);
            v  = (k < 256) && ($urandom_range(3) != 0);
            rr = ($urandom_range(2) != 0);
            applyStimulus(0, v, rc, rr, f);
            if (f) k++;
            budget--;
        end
        checkOutput("wrapResults", 32'(fireCount), 32'(256));
        checkOutput("wrapDrained", 32'(expQ.size()), 32'(0));
        checkOutput("wrapSaw255", 32'(saw255), 32'(1));
        checkOutput("wrapCnt", 32'(cnt[0]), 32'(0));
        checkOutput("wrapIdle", 32'(busy[0]), 32'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
